downsample_processor: RTL and testbench
=======================================

// Module: downsample_processor
// PURPOSE
//  Down-sampling core feeding the memory address controller: after the received image is in
//  memory, reads each 2x2 pixel block, writes its rounded mean to the output region, then flags
//  completion so transmission can start. Drives ProAddress/Pro_Dout/Pro_wea into the shared
//  single-port RAM via the controller, which muxes them onto MemAddress/MemData/wea.
//  Held in reset by Pro_rst while the image is received; runs once Pro_rst falls.
// PARAMETERS
//  IMG_W     256    input image width in pixels (even, >=2)
//  IMG_H     256    input image height in pixels (even, >=2)
//  IN_BASE   7      RAM address of input pixel (0,0); input row-major, IMG_W pixels per row
//  OUT_BASE  65543  RAM address of output pixel (0,0); output row-major, IMG_W/2 per row
//  ADDR_W    18     RAM address width
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  Pro_rst     in   1       synchronous, active-high reset; high = hold/restart
//  mem_dout    in   8       RAM read data, valid 1 cycle after ProAddress is presented
//  ProAddress  out  ADDR_W  RAM address (read or write)
//  Pro_Dout    out  8       RAM write data (averaged pixel)
//  Pro_wea     out  1       RAM write enable, 1-cycle pulse per output pixel
//  Pro_over    out  1       processing complete; sticky until Pro_rst
// BEHAVIOUR
//  Reset (Pro_rst=1 at clk edge): state=RD0, ox=oy=0, ProAddress=IN_BASE, Pro_Dout=0,
//   Pro_wea=0, Pro_over=0, sample regs cleared. Mid-operation reset aborts; no partial write
//   follows; processing restarts at pixel (0,0) on first edge with Pro_rst=0.
//  Output grid: ox in [0,IMG_W/2-1], oy in [0,IMG_H/2-1], raster order (ox fastest).
//  Input taps: p00=(2ox,2oy) p01=(2ox+1,2oy) p10=(2ox,2oy+1) p11=(2ox+1,2oy+1);
//   addr(x,y)=IN_BASE+y*IMG_W+x. Generate via incrementing base registers, no multipliers.
//  FSM, one output pixel per 6 cycles, all outputs registered:
//   RD0: ProAddress=addr(p00)                          -> RD1
//   RD1: ProAddress=addr(p01); acc<=mem_dout (p00)     -> RD2
//   RD2: ProAddress=addr(p10); acc+=mem_dout (p01)     -> RD3
//   RD3: ProAddress=addr(p11); acc+=mem_dout (p10)     -> CAP
//   CAP: ProAddress held;      acc+=mem_dout (p11)     -> WR
//   WR : ProAddress=OUT_BASE+oy*(IMG_W/2)+ox; Pro_Dout=(acc+2)>>2; Pro_wea=1
//        -> RD0 with ox+1 (wrap ox->0, oy+1 at row end); last pixel -> DONE
//   DONE: Pro_wea=0, Pro_over=1, ProAddress/Pro_Dout hold last values; stays until reset.
//  Pro_wea=0 in every state except WR; never two consecutive write cycles.
//  Arithmetic: acc 10-bit unsigned (max 1020); mean=(acc+2)>>2, round-half-up, max 255,
//   no saturation needed. Pro_Dout 8-bit = mean[7:0].
//  Latency: first write in cycle 6 after reset release (cycles numbered from 1);
//   Pro_over rises cycle 6*(IMG_W/2)*(IMG_H/2)+1 after release (98305 at defaults).
//  Output region must not overlap input region (OUT_BASE >= IN_BASE+IMG_W*IMG_H); sim
//   assertion fires otherwise, and on odd IMG_W/IMG_H.
// TESTING
//  1. Preload all 256x256 input = 0x80, release reset -> 16384 writes, all Pro_Dout=0x80,
//     addresses 65543..81926 ascending, Pro_over at cycle 98305.
//  2. First-pixel trace, default params -> ProAddress 7,8,263,264,264,65543 on cycles 1..6,
//     Pro_wea high only cycle 6.
//  3. Rounding: block values 1,1,1,2 -> 1; 1,1,2,2 -> 2 (6+2>>2); all 0xFF -> 0xFF.
//  4. Row wrap: pixel (127,0) reads 261,262,517,518 and writes 65670; next reads 519.
//  5. Assert Pro_rst for 1 cycle at cycle 5000 -> no Pro_wea next cycle, sequence restarts
//     at address 7, Pro_over only at 98305 cycles after the release.
//  6. IMG_W=4, IMG_H=2, OUT_BASE=100: inputs 10,20,30,40 / 50,60,70,80 -> writes 35@100,
//     55@101; Pro_over sticky at cycle 13, holds through 50 idle cycles.

Source files
------------

// File: rtl/downsample_processor.sv
// Down-sampling core: writes the rounded mean of every 2x2 input block to the output region.
// Six cycles per output pixel (four reads, capture, write), then a sticky completion flag.
module downsample_processor #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int IN_BASE  = 7,
    parameter int OUT_BASE = 65543,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              Pro_rst,
    input  logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] ProAddress,
    output logic [7:0]        Pro_Dout,
    output logic              Pro_wea,
    output logic              Pro_over
);
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam int XW = (OW > 1) ? $clog2(OW) : 1;
    localparam int YW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] ROW_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_A = ADDR_W'(2);
    localparam logic [XW-1:0]     X_LAST = XW'(OW - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(OH - 1);

    localparam bit PARAM_OK =
        (IMG_W >= 2) && (IMG_H >= 2) &&
        (IMG_W % 2 == 0) && (IMG_H % 2 == 0) &&
        (longint'(OUT_BASE) >=
         longint'(IN_BASE) + longint'(IMG_W) * longint'(IMG_H));

    typedef enum logic [2:0] {
        RD0, RD1, RD2, RD3, CAP, WR, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     ox_q, ox_d;
    logic [YW-1:0]     oy_q, oy_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [9:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              wea_q, wea_d;
    logic              over_q, over_d;
    logic [9:0]        sum;

    assign sum = acc_q + {2'b00, mem_dout};

    // Outputs are registered for the state being entered, so each
    // state's address is already on the bus while that state is current.
    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        base_d  = base_q;
        oaddr_d = oaddr_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wea_d   = 1'b0;
        over_d  = over_q;
        unique case (state_q)
            RD0: begin
                addr_d  = base_q + ONE_A;
                state_d = RD1;
            end
            RD1: begin
                acc_d   = {2'b00, mem_dout};
                addr_d  = base_q + ROW_A;
                state_d = RD2;
            end
            RD2: begin
                acc_d   = sum;
                addr_d  = base_q + ROW_A + ONE_A;
                state_d = RD3;
            end
            RD3: begin
                acc_d   = sum;
                state_d = CAP;
            end
            CAP: begin
                acc_d   = sum;
                dout_d  = 8'((sum + 10'd2) >> 2);
                addr_d  = oaddr_q;
                wea_d   = 1'b1;
                state_d = WR;
            end
            WR: begin
                oaddr_d = oaddr_q + ONE_A;
                if (ox_q == X_LAST && oy_q == Y_LAST) begin
                    over_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    // End of row skips the odd input row already consumed.
                    if (ox_q == X_LAST) begin
                        ox_d   = '0;
                        oy_d   = oy_q + YW'(1);
                        base_d = base_q + TWO_A + ROW_A;
                    end else begin
                        ox_d   = ox_q + XW'(1);
                        base_d = base_q + TWO_A;
                    end
                    addr_d  = base_d;
                    state_d = RD0;
                end
            end
            DONE: begin
                over_d = 1'b1;
            end
            default: state_d = RD0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Pro_rst) begin
            state_q <= RD0;
            ox_q    <= '0;
            oy_q    <= '0;
            base_q  <= IN_A;
            oaddr_q <= OUT_A;
            acc_q   <= '0;
            addr_q  <= IN_A;
            dout_q  <= '0;
            wea_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            base_q  <= base_d;
            oaddr_q <= oaddr_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wea_q   <= wea_d;
            over_q  <= over_d;
        end
    end

    assign ProAddress = addr_q;
    assign Pro_Dout   = dout_q;
    assign Pro_wea    = wea_q;
    assign Pro_over   = over_q;

    a_geometry: assert property (@(posedge clk) PARAM_OK)
        else $error("downsample_processor: odd size or overlapping regions");

    a_single_write: assert property (
        @(posedge clk) disable iff (Pro_rst) wea_q |=> !wea_q)
        else $error("downsample_processor: back-to-back writes");
endmodule

// File: tb/tb_downsample_processor.sv
// Directed bench: default-size core for trace/rounding/row wrap,
// a 4x2 core for reset abort, completion and done-hold.
module tb_downsample_processor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [7:0]  din_a, din_b;
    logic [17:0] addr_a, addr_b;
    logic [7:0]  dout_a, dout_b;
    logic        wea_a, wea_b, over_a, over_b;

    downsample_processor dut_a (
        .clk(clk), .Pro_rst(rst_a), .mem_dout(din_a),
        .ProAddress(addr_a), .Pro_Dout(dout_a),
        .Pro_wea(wea_a), .Pro_over(over_a)
    );

    downsample_processor #(
        .IMG_W(4), .IMG_H(2), .IN_BASE(7), .OUT_BASE(100), .ADDR_W(18)
    ) dut_b (
        .clk(clk), .Pro_rst(rst_b), .mem_dout(din_b),
        .ProAddress(addr_b), .Pro_Dout(dout_b),
        .Pro_wea(wea_b), .Pro_over(over_b)
    );

    logic [7:0] mem_a [0:262143];
    logic [7:0] mem_b [0:255];

    always @(posedge clk) begin
        din_a <= mem_a[addr_a];
        din_b <= mem_b[addr_b[7:0]];
    end

    typedef struct packed {
        logic [17:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t wq_a[$];

    always @(negedge clk) begin
        if (wea_a) wq_a.push_back({addr_a, dout_a});
    end

    typedef struct {
        int         ox;
        logic [7:0] p00, p01, p10, p11;
        logic [7:0] mean;
    } blk_t;

    typedef struct {
        int   addr;
        logic wea;
        logic over;
    } trc_t;

    blk_t blks [7];
    trc_t trc_b [13];
    int   tr_a [6];
    int   wrap_a [7];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int a;
        int exp_d;
        rst_a = 1'b1;
        rst_b = 1'b1;

        blks[0] = '{0,   8'd1,   8'd1,   8'd1,   8'd2,   8'd1};
        blks[1] = '{1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd2};
        blks[2] = '{2,   8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFF};
        blks[3] = '{3,   8'd0,   8'd0,   8'd0,   8'd1,   8'd0};
        blks[4] = '{4,   8'd0,   8'd0,   8'd1,   8'd1,   8'd1};
        blks[5] = '{5,   8'd10,  8'd20,  8'd50,  8'd60,  8'd35};
        blks[6] = '{127, 8'd10,  8'd20,  8'd30,  8'd41,  8'd25};

        tr_a   = '{7, 8, 263, 264, 264, 65543};
        wrap_a = '{261, 262, 517, 518, 518, 65670, 519};

        trc_b[0]  = '{7,   1'b0, 1'b0};
        trc_b[1]  = '{8,   1'b0, 1'b0};
        trc_b[2]  = '{11,  1'b0, 1'b0};
        trc_b[3]  = '{12,  1'b0, 1'b0};
        trc_b[4]  = '{12,  1'b0, 1'b0};
        trc_b[5]  = '{100, 1'b1, 1'b0};
        trc_b[6]  = '{9,   1'b0, 1'b0};
        trc_b[7]  = '{10,  1'b0, 1'b0};
        trc_b[8]  = '{13,  1'b0, 1'b0};
        trc_b[9]  = '{14,  1'b0, 1'b0};
        trc_b[10] = '{14,  1'b0, 1'b0};
        trc_b[11] = '{101, 1'b1, 1'b0};
        trc_b[12] = '{101, 1'b0, 1'b1};

        for (int i = 0; i < 262144; i++) mem_a[i] = 8'h80;
        for (int b = 0; b < 7; b++) begin
            a = 7 + 2 * blks[b].ox;
            mem_a[a]       = blks[b].p00;
            mem_a[a + 1]   = blks[b].p01;
            mem_a[a + 256] = blks[b].p10;
            mem_a[a + 257] = blks[b].p11;
        end
        for (int i = 0; i < 256; i++) mem_b[i] = 8'd0;
        for (int i = 0; i < 8; i++) mem_b[7 + i] = 8'((i + 1) * 10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_a", addr_a, 7);
        check("rst_dout_a", dout_a, 0);
        check("rst_wea_a", wea_a, 0);
        check("rst_over_a", over_a, 0);
        check("rst_addr_b", addr_b, 7);

        // Default core: first-pixel trace and row-0 wrap trace.
        rst_a = 1'b0;
        for (int c = 1; c <= 770; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 6) begin
                check($sformatf("trace_addr c%0d", c), addr_a, tr_a[c-1]);
                check($sformatf("trace_wea c%0d", c), wea_a, (c == 6) ? 1 : 0);
            end
            if (c >= 763 && c <= 769) begin
                check($sformatf("wrap_addr c%0d", c), addr_a, wrap_a[c-763]);
                check($sformatf("wrap_wea c%0d", c), wea_a, (c == 768) ? 1 : 0);
            end
        end
        check("over_a_busy", over_a, 0);
        rst_a = 1'b1;

        check("row0_writes", wq_a.size(), 128);
        for (int k = 0; k < wq_a.size() && k < 128; k++) begin
            exp_d = 8'h80;
            for (int b = 0; b < 7; b++)
                if (blks[b].ox == k) exp_d = blks[b].mean;
            check($sformatf("wr_addr %0d", k), wq_a[k].addr, 65543 + k);
            check($sformatf("wr_data %0d", k), wq_a[k].data, exp_d);
        end

        // Small core: abort just before the first write.
        rst_b = 1'b0;
        for (int c = 2; c <= 5; c++) @(negedge clk);
        check("abort_cap_addr", addr_b, 12);
        rst_b = 1'b1;
        @(negedge clk);
        check("abort_wea", wea_b, 0);
        check("abort_addr", addr_b, 7);
        check("abort_dout", dout_b, 0);

        rst_b = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("b_addr c%0d", c), addr_b, trc_b[c-1].addr);
            check($sformatf("b_wea c%0d", c), wea_b, trc_b[c-1].wea);
            check($sformatf("b_over c%0d", c), over_b, trc_b[c-1].over);
            if (c == 6) check("b_dout px0", dout_b, 35);
            if (c == 12) check("b_dout px1", dout_b, 55);
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check($sformatf("hold %0d", c), {over_b, wea_b}, 2'b10);
        end
        check("hold_addr", addr_b, 101);
        check("hold_dout", dout_b, 55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
